// File: rtl/patbuf_pkg.sv
// Shared types and constants for the pattern-buffer serial loader.
// Used by patbuf_loader and patbuf_clkdiv.
package patbuf_pkg;

   localparam int unsigned ADDR_W         = 3;
   localparam int unsigned DATA_W_DEFAULT = 8;
   localparam int unsigned DIV_CNT_W      = 8;

   typedef enum logic [2:0] {
      IDLE,
      SETUP,
      SHIFT_LO,
      SHIFT_HI,
      WAIT,
      HOLD
   } state_e;

endpackage

// File: rtl/patbuf_clkdiv.sv
// Half-period tick generator for the pattern-buffer serial clock.
// Counts CLK_DIV system clocks per tick; the FSM restarts it on every state change.
module patbuf_clkdiv
   import patbuf_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic restart,
   output logic tick
);

   localparam logic [DIV_CNT_W-1:0] TERM = DIV_CNT_W'(CLK_DIV - 1);

   logic [DIV_CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == TERM);
      cnt_d = cnt_q + 1'b1;
      if (restart || tick) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/patbuf_loader.sv
// Host-to-pattern-buffer serial loader: shifts bytes MSB first over sclk/sin/ssel.
// Optional readback of sout into rsp_data is enabled by defining PATBUF_LOADER_READBACK_EN.
module patbuf_loader
   import patbuf_pkg::*;
#(
   parameter int unsigned CLK_DIV = 2,
   parameter int unsigned DATA_W  = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_data,
   input  logic              req_last,
   input  logic              abort,
   output logic              sclk,
   output logic              sin,
   output logic              ssel,
   output logic [ADDR_W-1:0] saddr,
   input  logic              sout,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              busy
);

   localparam int unsigned       BIT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   tx_q, tx_d;
   logic [BIT_W-1:0]    bit_q, bit_d;
   logic                last_q, last_d;
   logic [ADDR_W-1:0]   saddr_q, saddr_d;
   logic                ready_q, ready_d;
   logic                hs;
   logic                tick;
   logic                restart;
   logic                sample;
   logic                byte_done;

   patbuf_clkdiv #(
      .CLK_DIV (CLK_DIV)
   ) u_clkdiv (
      .clk     (clk),
      .rst     (rst),
      .restart (restart),
      .tick    (tick)
   );

   always_comb begin
      hs        = req_valid && ready_q;
      state_d   = state_q;
      tx_d      = tx_q;
      bit_d     = bit_q;
      last_d    = last_q;
      saddr_d   = saddr_q;
      sample    = 1'b0;
      byte_done = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (hs) begin
               state_d = SETUP;
               tx_d    = req_data;
               last_d  = req_last;
               saddr_d = req_addr;
               bit_d   = '0;
            end
         end
         SETUP: begin
            if (abort) begin
               state_d = HOLD;
            end else if (tick) begin
               state_d = SHIFT_LO;
            end
         end
         SHIFT_LO: begin
            if (abort) begin
               state_d = HOLD;
            end else if (tick) begin
               state_d = SHIFT_HI;
               sample  = 1'b1;
            end
         end
         SHIFT_HI: begin
            if (abort) begin
               state_d = HOLD;
            end else if (tick) begin
               tx_d = tx_q << 1;
               if (bit_q == LAST_BIT) begin
                  byte_done = 1'b1;
                  state_d   = last_q ? HOLD : WAIT;
               end else begin
                  bit_d   = bit_q + 1'b1;
                  state_d = SHIFT_LO;
               end
            end
         end
         WAIT: begin
            // abort wins over a simultaneous handshake; the offered byte is dropped
            if (abort) begin
               state_d = HOLD;
            end else if (hs) begin
               state_d = SHIFT_LO;
               tx_d    = req_data;
               last_d  = req_last;
               bit_d   = '0;
            end
         end
         HOLD: begin
            if (tick) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      restart = (state_d != state_q);
      ready_d = (state_d == IDLE) || (state_d == WAIT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tx_q    <= '0;
         bit_q   <= '0;
         last_q  <= 1'b0;
         saddr_q <= '0;
         ready_q <= 1'b0;
      end else begin
         state_q <= state_d;
         tx_q    <= tx_d;
         bit_q   <= bit_d;
         last_q  <= last_d;
         saddr_q <= saddr_d;
         ready_q <= ready_d;
      end
   end

   // abort pulls sclk low combinationally in the cycle it is seen
   assign sclk      = (state_q == SHIFT_HI) && !abort;
   assign sin       = ((state_q == SHIFT_LO) || (state_q == SHIFT_HI)) ? tx_q[DATA_W-1] : 1'b0;
   assign ssel      = (state_q != IDLE);
   assign busy      = (state_q != IDLE);
   assign saddr     = saddr_q;
   assign req_ready = ready_q;

`ifdef PATBUF_LOADER_READBACK_EN
   logic [DATA_W-1:0] rx_q, rx_d;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              rsp_valid_q, rsp_valid_d;

   always_comb begin
      rx_d        = rx_q;
      rsp_data_d  = rsp_data_q;
      rsp_valid_d = 1'b0;
      if (sample) begin
         rx_d = {rx_q[DATA_W-2:0], sout};
      end
      if (byte_done) begin
         rsp_valid_d = 1'b1;
         rsp_data_d  = rx_q;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_q        <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
      end else begin
         rx_q        <= rx_d;
         rsp_data_q  <= rsp_data_d;
         rsp_valid_q <= rsp_valid_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
`else
   logic unused_rb;

   assign unused_rb = ^{sout, sample, byte_done};
   assign rsp_valid = 1'b0;
   assign rsp_data  = '0;
`endif

endmodule
